pstore_drain: RTL and testbench

Readout engine on the far side of the partial-sum store. When a layer's accumulation finishes, it snapshots all per-node partial sums in one cycle and pulses a clear back to the store so the next accumulation can start. It then applies ReLU and optional saturation to each sum and streams the results one node per beat to the next layer over a valid/ready handshake.

---
 rtl/pstore_drain_pkg.sv | 35 +++
 rtl/relu_sat.sv | 30 +++
 rtl/pstore_drain.sv | 133 +++++++++++++
 tb/tb_pstore_drain.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pstore_drain_pkg.sv
// Shared drain constants: node count, partial-sum width and drain state encodings.
// Optional RELU_DRAIN_SAT_EN (see relu_sat) selects saturating narrowing.
`ifndef RELU_NODES
`define RELU_NODES 2
`endif
`ifndef LAYER_1_OUT_BIT_WIDTH
`define LAYER_1_OUT_BIT_WIDTH 5
`endif
`ifndef IDLE
`define IDLE 2'd0
`endif
`ifndef LOAD
`define LOAD 2'd1
`endif
`ifndef SEND
`define SEND 2'd2
`endif
`ifndef DONE
`define DONE 2'd3
`endif

package pstore_drain_pkg;

   typedef enum logic [1:0] {
      StIdle = `IDLE,
      StLoad = `LOAD,
      StSend = `SEND,
      StDone = `DONE
   } drain_state_e;

   function automatic int unsigned idx_width(input int unsigned nodes);
      return (nodes > 1) ? $clog2(nodes) : 1;
   endfunction

endpackage

// File: rtl/relu_sat.sv
// ReLU activation: negative sums become 0, others are narrowed to OUT_W bits.
// RELU_DRAIN_SAT_EN defined: clamp to 2^OUT_W-1; undefined: keep the low OUT_W bits.
module relu_sat #(
   parameter int unsigned IN_W  = 5,
   parameter int unsigned OUT_W = 3
) (
   input  logic [IN_W-1:0]  sum_i,
   output logic [OUT_W-1:0] act_o
);

`ifdef RELU_DRAIN_SAT_EN
   localparam logic [IN_W-1:0] MaxOut = IN_W'((1 << OUT_W) - 1);
`endif

   always_comb begin
      act_o = '0;
      if (!sum_i[IN_W-1]) begin
`ifdef RELU_DRAIN_SAT_EN
         if (sum_i > MaxOut) begin
            act_o = '1;
         end else begin
            act_o = OUT_W'(sum_i);
         end
`else
         act_o = OUT_W'(sum_i);
`endif
      end
   end

endmodule

// File: rtl/pstore_drain.sv
// Partial-sum store readout: snapshot all sums, clear the store, stream ReLU results per node.
// Saturation vs truncation is chosen by RELU_DRAIN_SAT_EN inside relu_sat.
module pstore_drain
   import pstore_drain_pkg::*;
#(
   parameter int unsigned NODES = `RELU_NODES,
   parameter int unsigned IN_W  = `LAYER_1_OUT_BIT_WIDTH,
   parameter int unsigned OUT_W = 3,
   parameter int unsigned IDX_W = idx_width(NODES)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [NODES*IN_W-1:0] sumIn,
   output logic                  storeClr,
   output logic [OUT_W-1:0]      outData,
   output logic [IDX_W-1:0]      outIndex,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NODES - 1);

   drain_state_e                  state_q, state_d;
   logic [NODES-1:0][IN_W-1:0]    shadow_q, shadow_d;
   logic [IDX_W-1:0]              idx_q, idx_d;

   logic                          store_clr_q, store_clr_d;
   logic [OUT_W-1:0]              data_q, data_d;
   logic [IDX_W-1:0]              index_q, index_d;
   logic                          valid_q, valid_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          overrun_q, overrun_d;

   logic [IN_W-1:0]               word_d;
   logic [OUT_W-1:0]              act_d;
   logic                          fire;

   assign fire = valid_q && outReady;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= StIdle;
         shadow_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               shadow_d = sumIn;
               idx_d    = '0;
               state_d  = StLoad;
            end
         end
         StLoad: state_d = StSend;
         StSend: begin
            if (fire) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Activation is computed on next-state values so the output register holds the new beat.
   assign word_d = shadow_d[idx_d];

   relu_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_relu_sat (
      .sum_i (word_d),
      .act_o (act_d)
   );

   always_comb begin
      store_clr_d = (state_d == StLoad);
      valid_d     = (state_d == StSend);
      data_d      = valid_d ? act_d : '0;
      index_d     = valid_d ? idx_d : '0;
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      overrun_d   = start && (state_q != StIdle);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         store_clr_q <= 1'b0;
         data_q      <= '0;
         index_q     <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         store_clr_q <= store_clr_d;
         data_q      <= data_d;
         index_q     <= index_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign storeClr = store_clr_q;
   assign outData  = data_q;
   assign outIndex = index_q;
   assign outValid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_pstore_drain.sv
// Bench for pstore_drain: directed scenarios plus randomized drains against a ReLU reference model.
// Follows RELU_DRAIN_SAT_EN to choose the expected narrowing.
module tb_pstore_drain;

   localparam int NODES = 2;
   localparam int IN_W  = 5;
   localparam int OUT_W = 3;
   localparam int IDX_W = 1;

   logic                  clk = 1'b0;
   logic                  clr = 1'b1;
   logic                  start = 1'b0;
   logic [NODES*IN_W-1:0] sumIn = '0;
   logic                  outReady = 1'b0;
   logic                  storeClr, outValid, busy, done, overrun;
   logic [OUT_W-1:0]      outData;
   logic [IDX_W-1:0]      outIndex;

   int n_cmp = 0;
   int n_err = 0;

   wire [3:0] ctl = {storeClr, outValid, busy, done};

   pstore_drain #(
      .NODES (NODES),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .IDX_W (IDX_W)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .sumIn    (sumIn),
      .storeClr (storeClr),
      .outData  (outData),
      .outIndex (outIndex),
      .outValid (outValid),
      .outReady (outReady),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Reference activation from the arithmetic rule: negative -> 0, else narrow.
   function automatic logic [OUT_W-1:0] act_ref(input logic [NODES*IN_W-1:0] v, input int i);
      logic [IN_W-1:0] w;
      int s;
      w = v[i*IN_W +: IN_W];
      s = int'($signed(w));
      if (s < 0) return '0;
`ifdef RELU_DRAIN_SAT_EN
      if (s > (1 << OUT_W) - 1) s = (1 << OUT_W) - 1;
`endif
      return OUT_W'(s % (1 << OUT_W));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start = i[0];
         sumIn = 10'(($urandom));
         tick();
         n_cmp++;
         if ({ctl, overrun, outData, outIndex} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {ctl, overrun, outData, outIndex});
         end
      end
      start = 1'b0;
      clr   = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [9:0] v;
      v = 10'b11111_01010;
      sumIn = v;
      outReady = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (ctl !== 4'b1010) begin
         n_err++; $display("FAIL basic_load: ctl got %b want 1010", ctl);
      end
      tick();
      n_cmp++;
      if ({ctl, outIndex, outData} !== {4'b0110, 1'b0, act_ref(v, 0)}) begin
         n_err++;
         $display("FAIL basic_beat0: got %b/%0d/%0d want 0110/0/%0d", ctl, outIndex, outData,
                  act_ref(v, 0));
      end
      tick();
      n_cmp++;
      if ({ctl, outIndex, outData} !== {4'b0110, 1'b1, act_ref(v, 1)}) begin
         n_err++;
         $display("FAIL basic_beat1: got %b/%0d/%0d want 0110/1/%0d", ctl, outIndex, outData,
                  act_ref(v, 1));
      end
      tick();
      n_cmp++;
      if (ctl !== 4'b0011) begin
         n_err++; $display("FAIL basic_done: ctl got %b want 0011", ctl);
      end
      tick();
      n_cmp++;
      if (ctl !== 4'b0000) begin
         n_err++; $display("FAIL basic_idle: ctl got %b want 0000", ctl);
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] v;
      v = 10'b00011_00101;
      sumIn = v;
      outReady = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) outReady = 1'b1;
         n_cmp++;
         if ({outValid, outIndex, outData} !== {1'b1, 1'b0, act_ref(v, 0)}) begin
            n_err++;
            $display("FAIL bp_hold%0d: got %b/%0d/%0d want 1/0/%0d", i, outValid, outIndex,
                     outData, act_ref(v, 0));
         end
         tick();
      end
      n_cmp++;
      if ({outValid, outIndex, outData} !== {1'b1, 1'b1, act_ref(v, 1)}) begin
         n_err++;
         $display("FAIL bp_beat1: got %b/%0d/%0d want 1/1/%0d", outValid, outIndex, outData,
                  act_ref(v, 1));
      end
      tick();
      n_cmp++;
      if (ctl !== 4'b0011) begin
         n_err++; $display("FAIL bp_done: ctl got %b want 0011", ctl);
      end
      tick();
   endtask

   task automatic test_capture();
      logic [9:0] v;
      v = 10'b00010_00110;
      sumIn = v;
      outReady = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      sumIn = 10'b01111_01111;
      for (int i = 0; i < NODES; i++) begin
         tick();
         n_cmp++;
         if ({outValid, outIndex, outData} !== {1'b1, IDX_W'(i), act_ref(v, i)}) begin
            n_err++;
            $display("FAIL capture_beat%0d: got %b/%0d/%0d want 1/%0d/%0d", i, outValid, outIndex,
                     outData, i, act_ref(v, i));
         end
      end
      tick();
      tick();
   endtask

   task automatic test_overrun();
      logic [9:0] v;
      v = 10'b00100_11000;
      sumIn = v;
      outReady = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      sumIn = 10'b00111_00111;
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++; $display("FAIL ovr_early: got %b want 0", overrun);
      end
      tick();
      start = 1'b0;
      n_cmp++;
      if ({overrun, outValid, outIndex, outData} !== {2'b11, 1'b1, act_ref(v, 1)}) begin
         n_err++;
         $display("FAIL ovr_pulse: got %b/%b/%0d/%0d want 1/1/1/%0d", overrun, outValid, outIndex,
                  outData, act_ref(v, 1));
      end
      tick();
      start = 1'b1;
      n_cmp++;
      if ({overrun, ctl} !== 5'b0_0011) begin
         n_err++; $display("FAIL ovr_done: got %b want 00011", {overrun, ctl});
      end
      tick();
      start = 1'b0;
      n_cmp++;
      if ({overrun, ctl} !== 5'b1_0000) begin
         n_err++; $display("FAIL ovr_in_done: got %b want 10000", {overrun, ctl});
      end
      tick();
      n_cmp++;
      if ({overrun, ctl} !== 5'b0_0000) begin
         n_err++; $display("FAIL ovr_clear: got %b want 00000", {overrun, ctl});
      end
   endtask

   task automatic test_abort();
      logic [9:0] v;
      v = 10'b00001_00110;
      sumIn = v;
      outReady = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      clr = 1'b1;
      #1;
      n_cmp++;
      if ({ctl, outData, outIndex} !== '0) begin
         n_err++; $display("FAIL abort_now: got %b want 0", {ctl, outData, outIndex});
      end
      tick();
      clr = 1'b0;
      outReady = 1'b1;
      tick();
      n_cmp++;
      if (ctl !== 4'b0000) begin
         n_err++; $display("FAIL abort_nodone: ctl got %b want 0000", ctl);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < NODES; i++) begin
         n_cmp++;
         if ({outValid, outIndex, outData} !== {1'b1, IDX_W'(i), act_ref(v, i)}) begin
            n_err++;
            $display("FAIL abort_restart%0d: got %b/%0d/%0d want 1/%0d/%0d", i, outValid,
                     outIndex, outData, i, act_ref(v, i));
         end
         tick();
      end
      n_cmp++;
      if (ctl !== 4'b0011) begin
         n_err++; $display("FAIL abort_done: ctl got %b want 0011", ctl);
      end
      tick();
   endtask

   task automatic test_random();
      logic [9:0] v;
      int idx;
      int cyc;
      logic rdy;
      for (int n = 0; n < 40; n++) begin
         v = 10'($urandom);
         sumIn = v;
         outReady = 1'($urandom_range(0, 1));
         start = 1'b1;
         tick();
         start = 1'b0;
         sumIn = 10'($urandom);
         n_cmp++;
         if (ctl !== 4'b1010) begin
            n_err++; $display("FAIL rnd_load%0d: ctl got %b want 1010", n, ctl);
         end
         tick();
         idx = 0;
         cyc = 0;
         while (idx < NODES && cyc < 64) begin
            n_cmp++;
            if ({ctl, outIndex, outData} !== {4'b0110, IDX_W'(idx), act_ref(v, idx)}) begin
               n_err++;
               $display("FAIL rnd_beat%0d_%0d: got %b/%0d/%0d want 0110/%0d/%0d", n, idx, ctl,
                        outIndex, outData, idx, act_ref(v, idx));
            end
            rdy = 1'($urandom_range(0, 1));
            outReady = rdy;
            sumIn = 10'($urandom);
            tick();
            if (rdy) idx++;
            cyc++;
         end
         n_cmp++;
         if (cyc >= 64 || ctl !== 4'b0011) begin
            n_err++; $display("FAIL rnd_done%0d: ctl got %b want 0011 (cycles %0d)", n, ctl, cyc);
         end
         tick();
         n_cmp++;
         if (ctl !== 4'b0000) begin
            n_err++; $display("FAIL rnd_idle%0d: ctl got %b want 0000", n, ctl);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_capture();
      test_overrun();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
